// File: rtl/sargantana_icache_pkg.sv
// Shared types and size helpers for the icache instruction-fill engine.
package sargantana_icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ifill_state_t;

  localparam int DEF_PADDR_W = 40;
  localparam int DEF_LINE_W  = 512;
  localparam int DEF_BEAT_W  = 128;

  function automatic int calc_n_beats(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  // A single-beat line still needs a 1-bit counter to keep widths legal.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  localparam int N_BEATS    = calc_n_beats(DEF_LINE_W, DEF_BEAT_W);
  localparam int BEAT_CNT_W = calc_cnt_w(N_BEATS);
  localparam int LINE_OFF_W = calc_off_w(DEF_LINE_W);

endpackage

// File: rtl/sargantana_icache_line_buf.sv
// Beat-indexed line register: one BEAT_W slot written per accepted beat,
// read back as a flat line with beat 0 in the low bits.
module sargantana_icache_line_buf
  import sargantana_icache_pkg::*;
#(
  parameter int BEAT_W  = DEF_BEAT_W,
  parameter int N_BEATS = 4,
  parameter int CNT_W   = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      we,
  input  logic [CNT_W-1:0]          idx,
  input  logic [BEAT_W-1:0]         wdata,
  output logic [N_BEATS*BEAT_W-1:0] line
);

  logic [N_BEATS-1:0][BEAT_W-1:0] beats;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      beats <= '0;
    end else if (we) begin
      beats[idx] <= wdata;
    end
  end

  assign line = beats;

endmodule

// File: rtl/sargantana_icache_ifill.sv
// Instruction-fill engine: one line read to L2, beat collection, line handback.
// Optional watchdog on the response phase: SARGANTANA_ICACHE_IFILL_TIMEOUT_EN.
module sargantana_icache_ifill
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_W = DEF_PADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int BEAT_W  = DEF_BEAT_W
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               ifill_req_valid_i,
  input  logic [PADDR_W-1:0] ifill_req_paddr_i,
  input  logic               kill_i,
  output logic               l2_req_valid_o,
  input  logic               l2_req_ready_i,
  output logic [PADDR_W-1:0] l2_req_paddr_o,
  input  logic               l2_rsp_valid_i,
  input  logic [BEAT_W-1:0]  l2_rsp_data_i,
  input  logic               l2_rsp_err_i,
  output logic               ifill_sent_ack_o,
  output logic               ifill_resp_valid_o,
  output logic               valid_ifill_resp_o,
  output logic [LINE_W-1:0]  ifill_line_o,
  output logic               ifill_err_o,
  output logic               busy_o
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
  ,output logic              timeout_o
`endif
);

  localparam int NB    = calc_n_beats(LINE_W, BEAT_W);
  localparam int CNT_W = calc_cnt_w(NB);
  localparam int OFF_W = calc_off_w(LINE_W);
  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(NB - 1);
  localparam logic [PADDR_W-1:0] ALIGN_MASK = {PADDR_W{1'b1}} << OFF_W;

  ifill_state_t     state;
  logic [CNT_W-1:0] beat_cnt;
  logic             drop;
  logic             err_acc;
  logic             beat_we;

`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
  localparam int TO_W = calc_cnt_w(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Beats are only ever taken in WAIT; dropped fills still land in the buffer.
  assign beat_we            = l2_rsp_valid_i && (state == WAIT);
  assign ifill_resp_valid_o = beat_we && !drop && !kill_i;

  sargantana_icache_line_buf #(
    .BEAT_W  (BEAT_W),
    .N_BEATS (NB),
    .CNT_W   (CNT_W)
  ) u_line_buf (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .we     (beat_we),
    .idx    (beat_cnt),
    .wdata  (l2_rsp_data_i),
    .line   (ifill_line_o)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state              <= IDLE;
      beat_cnt           <= '0;
      drop               <= 1'b0;
      err_acc            <= 1'b0;
      l2_req_valid_o     <= 1'b0;
      l2_req_paddr_o     <= '0;
      ifill_sent_ack_o   <= 1'b0;
      valid_ifill_resp_o <= 1'b0;
      ifill_err_o        <= 1'b0;
      busy_o             <= 1'b0;
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
      to_cnt             <= '0;
      timeout_o          <= 1'b0;
`endif
    end else begin
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ifill_req_valid_i) begin
            l2_req_paddr_o <= ifill_req_paddr_i & ALIGN_MASK;
            beat_cnt       <= '0;
            drop           <= 1'b0;
            err_acc        <= 1'b0;
            l2_req_valid_o <= 1'b1;
            busy_o         <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          // Once L2 has accepted, a kill can no longer withdraw: drain instead.
          if (l2_req_ready_i) begin
            l2_req_valid_o   <= 1'b0;
            ifill_sent_ack_o <= 1'b1;
            drop             <= kill_i;
            state            <= WAIT;
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
            to_cnt           <= '0;
`endif
          end else if (kill_i) begin
            l2_req_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            state          <= IDLE;
          end
        end
        WAIT: begin
          if (kill_i) drop <= 1'b1;
          if (l2_rsp_valid_i) begin
            err_acc <= err_acc | l2_rsp_err_i;
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
            to_cnt  <= '0;
`endif
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt         <= '0;
              ifill_sent_ack_o <= 1'b0;
              if (drop || kill_i) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                valid_ifill_resp_o <= 1'b1;
                ifill_err_o        <= err_acc | l2_rsp_err_i;
                state              <= DONE;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            timeout_o        <= 1'b1;
            ifill_sent_ack_o <= 1'b0;
            beat_cnt         <= '0;
            if (drop || kill_i) begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              valid_ifill_resp_o <= 1'b1;
              ifill_err_o        <= 1'b1;
              state              <= DONE;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          valid_ifill_resp_o <= 1'b0;
          ifill_err_o        <= 1'b0;
          busy_o             <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// Randomized and directed bench for sargantana_icache_ifill against a
// transaction-level reference (aligned address, beat list, kill point).
module tb_sargantana_icache_ifill;
  import sargantana_icache_pkg::*;

  localparam int PADDR_W = 40;
  localparam int LINE_W  = 512;
  localparam int BEAT_W  = 128;
  localparam int NB      = LINE_W / BEAT_W;
  localparam int LINE_B  = LINE_W / 8;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic               ifill_req_valid_i;
  logic [PADDR_W-1:0] ifill_req_paddr_i;
  logic               kill_i;
  logic               l2_req_valid_o;
  logic               l2_req_ready_i;
  logic [PADDR_W-1:0] l2_req_paddr_o;
  logic               l2_rsp_valid_i;
  logic [BEAT_W-1:0]  l2_rsp_data_i;
  logic               l2_rsp_err_i;
  logic               ifill_sent_ack_o;
  logic               ifill_resp_valid_o;
  logic               valid_ifill_resp_o;
  logic [LINE_W-1:0]  ifill_line_o;
  logic               ifill_err_o;
  logic               busy_o;
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
  logic               timeout_o;
`endif

  always #5 clk_i = ~clk_i;

  sargantana_icache_ifill #(
    .PADDR_W (PADDR_W),
    .LINE_W  (LINE_W),
    .BEAT_W  (BEAT_W)
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
    ,.TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk_i              (clk_i),
    .rstn_i             (rstn_i),
    .ifill_req_valid_i  (ifill_req_valid_i),
    .ifill_req_paddr_i  (ifill_req_paddr_i),
    .kill_i             (kill_i),
    .l2_req_valid_o     (l2_req_valid_o),
    .l2_req_ready_i     (l2_req_ready_i),
    .l2_req_paddr_o     (l2_req_paddr_o),
    .l2_rsp_valid_i     (l2_rsp_valid_i),
    .l2_rsp_data_i      (l2_rsp_data_i),
    .l2_rsp_err_i       (l2_rsp_err_i),
    .ifill_sent_ack_o   (ifill_sent_ack_o),
    .ifill_resp_valid_o (ifill_resp_valid_o),
    .valid_ifill_resp_o (valid_ifill_resp_o),
    .ifill_line_o       (ifill_line_o),
    .ifill_err_o        (ifill_err_o),
    .busy_o             (busy_o)
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
    ,.timeout_o         (timeout_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-fill stimulus, filled in before each call to run_fill.
  logic [BEAT_W-1:0] bd [NB];
  logic              be [NB];
  int                bg [NB];
  logic [LINE_W-1:0] last_line;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [BEAT_W-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // kill_mode: 0 none, 1 kill while request pending, 2 kill on beat kill_beat
  task automatic run_fill(input logic [PADDR_W-1:0] pa, input int rdy_dly,
                          input int kill_mode, input int kill_beat, input bit spurious);
    logic [PADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0]  exp_line;
    logic               exp_err;
    bit                 dropped;
    int                 nresp;
    exp_addr = (pa / PADDR_W'(LINE_B)) * PADDR_W'(LINE_B);
    exp_line = '0;
    exp_err  = 1'b0;
    for (int b = 0; b < NB; b++) begin
      exp_line[b*BEAT_W +: BEAT_W] = bd[b];
      exp_err = exp_err | be[b];
    end

    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = pa;
    tick();
    ifill_req_valid_i = 1'b0;
    ifill_req_paddr_i = {8'($urandom), $urandom};
    chk("req_valid", l2_req_valid_o, 1'b1);
    chk("req_addr", l2_req_paddr_o, exp_addr);
    chk("ack_in_req", ifill_sent_ack_o, 1'b0);
    chk("busy_req", busy_o, 1'b1);

    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("req_hold_valid", l2_req_valid_o, 1'b1);
      chk("req_hold_addr", l2_req_paddr_o, exp_addr);
      chk("req_hold_noack", ifill_sent_ack_o, 1'b0);
    end

    if (kill_mode == 1) begin
      kill_i = 1'b1;
      tick();
      kill_i = 1'b0;
      chk("kreq_valid", l2_req_valid_o, 1'b0);
      chk("kreq_busy", busy_o, 1'b0);
      chk("kreq_ack", ifill_sent_ack_o, 1'b0);
      tick();
      chk("kreq_noline", valid_ifill_resp_o, 1'b0);
      return;
    end

    l2_req_ready_i = 1'b1;
    tick();
    l2_req_ready_i = 1'b0;
    chk("hs_valid_drop", l2_req_valid_o, 1'b0);
    chk("hs_ack", ifill_sent_ack_o, 1'b1);

    dropped = 1'b0;
    nresp   = 0;
    for (int b = 0; b < NB; b++) begin
      for (int g = 0; g < bg[b]; g++) begin
        #2;
        chk("gap_rv", ifill_resp_valid_o, 1'b0);
        tick();
        chk("gap_ack", ifill_sent_ack_o, 1'b1);
      end
      l2_rsp_valid_i    = 1'b1;
      l2_rsp_data_i     = bd[b];
      l2_rsp_err_i      = be[b];
      kill_i            = (kill_mode == 2) && (b == kill_beat);
      ifill_req_valid_i = spurious && (b == 0);
      #2;
      chk("beat_rv", ifill_resp_valid_o, !dropped && !kill_i);
      if (ifill_resp_valid_o) nresp++;
      if (kill_i) dropped = 1'b1;
      tick();
      l2_rsp_valid_i    = 1'b0;
      l2_rsp_err_i      = 1'b0;
      kill_i            = 1'b0;
      ifill_req_valid_i = 1'b0;
      if (b < NB - 1) chk("beat_ack", ifill_sent_ack_o, 1'b1);
    end

    chk("nresp", nresp, (kill_mode == 2) ? kill_beat : NB);
    chk("end_ack", ifill_sent_ack_o, 1'b0);
    chk("line_vld", valid_ifill_resp_o, !dropped);
    chk("end_busy", busy_o, !dropped);
    if (!dropped) begin
      chk("line", ifill_line_o, exp_line);
      chk("line_err", ifill_err_o, exp_err);
      last_line = exp_line;
    end
    tick();
    chk("pulse_len", valid_ifill_resp_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_reqv", l2_req_valid_o, 1'b0);
    if (!dropped) chk("line_hold", ifill_line_o, exp_line);
  endtask

  task automatic set_beats(input bit rnd, input int err_beat);
    for (int b = 0; b < NB; b++) begin
      bd[b] = rnd ? rand_beat() : BEAT_W'(10 + b);
      be[b] = (b == err_beat);
      bg[b] = 0;
    end
  endtask

`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
  task automatic run_timeout();
    int k;
    ifill_req_valid_i = 1'b1;
    ifill_req_paddr_i = 40'h00_4000_0040;
    tick();
    ifill_req_valid_i = 1'b0;
    l2_req_ready_i    = 1'b1;
    tick();
    l2_req_ready_i    = 1'b0;
    l2_rsp_valid_i    = 1'b1;
    l2_rsp_data_i     = 128'h1234;
    tick();
    l2_rsp_valid_i    = 1'b0;
    k = 0;
    while (k < 100 && !timeout_o) begin
      tick();
      k++;
    end
    chk("to_delay", k, 16);
    chk("to_line_vld", valid_ifill_resp_o, 1'b1);
    chk("to_err", ifill_err_o, 1'b1);
    chk("to_beat0", ifill_line_o[BEAT_W-1:0], 128'h1234);
    tick();
    chk("to_pulse", timeout_o, 1'b0);
    chk("to_idle", busy_o, 1'b0);
    l2_rsp_valid_i = 1'b1;
    #2;
    chk("to_late_beat", ifill_resp_valid_o, 1'b0);
    tick();
    l2_rsp_valid_i = 1'b0;
    chk("to_late_idle", busy_o, 1'b0);
  endtask
`endif

  initial begin
    rstn_i            = 1'b0;
    ifill_req_valid_i = 1'b0;
    ifill_req_paddr_i = '0;
    kill_i            = 1'b0;
    l2_req_ready_i    = 1'b0;
    l2_rsp_valid_i    = 1'b0;
    l2_rsp_data_i     = '0;
    l2_rsp_err_i      = 1'b0;
    last_line         = '0;
    repeat (3) tick();
    chk("rst_reqv", l2_req_valid_o, 1'b0);
    chk("rst_addr", l2_req_paddr_o, '0);
    rstn_i = 1'b1;
    tick();
    chk("rst_ack", ifill_sent_ack_o, 1'b0);
    chk("rst_vld", valid_ifill_resp_o, 1'b0);
    chk("rst_line", ifill_line_o, '0);
    chk("rst_err", ifill_err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);

    set_beats(1'b0, -1);
    run_fill(40'h00_8000_1234, 0, 0, 0, 1'b0);
    set_beats(1'b1, -1);
    run_fill(40'h00_8000_1234, 5, 0, 0, 1'b0);
    set_beats(1'b1, -1);
    run_fill(40'h12_3456_789A, 0, 2, 1, 1'b0);
    set_beats(1'b1, -1);
    run_fill(40'h00_0000_00FF, 2, 1, 0, 1'b0);
    set_beats(1'b1, 2);
    run_fill(40'hFF_FFFF_FFC1, 1, 0, 0, 1'b0);
    set_beats(1'b1, -1);
    run_fill(40'h00_0BAD_F00D, 0, 0, 0, 1'b0);
`ifdef SARGANTANA_ICACHE_IFILL_TIMEOUT_EN
    run_timeout();
`endif

    for (int t = 0; t < 60; t++) begin
      int km;
      for (int b = 0; b < NB; b++) begin
        bd[b] = rand_beat();
        be[b] = ($urandom_range(7) == 0);
        bg[b] = $urandom_range(3);
      end
      km = $urandom_range(3);
      run_fill({8'($urandom), $urandom}, $urandom_range(4), (km == 3) ? 0 : km,
               $urandom_range(NB - 1), $urandom_range(1) == 1);
    end

    // A stray beat while idle must neither be flagged nor land in the buffer.
    set_beats(1'b1, -1);
    run_fill(40'h00_2000_0000, 0, 0, 0, 1'b0);
    l2_rsp_valid_i = 1'b1;
    l2_rsp_data_i  = rand_beat();
    #2;
    chk("idle_beat_rv", ifill_resp_valid_o, 1'b0);
    tick();
    l2_rsp_valid_i = 1'b0;
    chk("idle_beat_busy", busy_o, 1'b0);
    chk("idle_beat_line", ifill_line_o, last_line);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_ifill.md
Name: sargantana_icache_ifill

Overview:
- Instruction-fill engine directly downstream of the icache controller FSM.
- Accepts a single line-fill request from the controller's MISS path and issues one line-aligned read to the L2 interface.
- Collects N_BEATS in-order response beats into a line buffer and hands the full line back with a one-cycle valid.
- Drives the controller's ifill_sent_ack / ifill_resp_valid / valid_ifill_resp inputs. Drains killed fills silently.

Parameters:
- PADDR_W, 40, physical address width.
- LINE_W, 512, cache line width in bits.
- BEAT_W, 128, L2 response beat width. LINE_W must be a multiple of BEAT_W; N_BEATS = LINE_W/BEAT_W.
- TIMEOUT_CYC, 1024, watchdog limit (optional feature only).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- ifill_req_valid_i  in  1  fill request from the controller (one-cycle pulse)
- ifill_req_paddr_i  in  PADDR_W  miss physical address
- kill_i  in  1  flush or kill from the core; the current fill is dropped
- l2_req_valid_o  out  1  L2 read request valid
- l2_req_ready_i  in  1  L2 accepts the request
- l2_req_paddr_o  out  PADDR_W  line-aligned address (low log2(LINE_W/8) bits zero)
- l2_rsp_valid_i  in  1  response beat valid
- l2_rsp_data_i  in  BEAT_W  response beat data
- l2_rsp_err_i  in  1  bus error on this beat
- ifill_sent_ack_o  out  1  transaction outstanding (request sent, line not complete)
- ifill_resp_valid_o  out  1  a beat was accepted this cycle and the fill is not dropped
- valid_ifill_resp_o  out  1  complete line available (one-cycle pulse)
- ifill_line_o  out  LINE_W  assembled line; beat 0 is in bits [BEAT_W-1:0]
- ifill_err_o  out  1  qualifies valid_ifill_resp_o: at least one beat had an error
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0, line buffer 0, beat counter 0, drop flag 0, error flag 0.
- FSM states and transitions:
  - IDLE: on ifill_req_valid_i, latch the aligned address, clear the counter and flags, go to REQ. A request arriving in any other state is ignored; the controller guarantees one outstanding fill.
  - REQ:
    - l2_req_valid_o = 1, held stable until l2_req_ready_i. On the handshake, go to WAIT.
    - If kill_i is seen in REQ before the handshake, withdraw the request and return to IDLE. The valid drop is permitted only on kill.
  - WAIT:
    - ifill_sent_ack_o = 1.
    - Each l2_rsp_valid_i writes the beat into slot beat_cnt and increments the counter.
    - On beat N_BEATS-1, go to DONE if not dropped, otherwise to IDLE.
  - DONE: valid_ifill_resp_o = 1 and ifill_sent_ack_o = 0 for exactly one cycle, then go to IDLE.
- Beat counter width is clog2(N_BEATS). It wraps to 0 on the last beat. No beat is ever accepted outside WAIT.
- ifill_resp_valid_o = l2_rsp_valid_i & (state == WAIT) & !drop & !kill_i. This is combinational on the beat cycle.
- Kill in WAIT:
  - Sets the drop flag, which is sticky until IDLE.
  - All remaining beats are still consumed.
  - ifill_sent_ack_o stays 1 until the last beat, so the controller's KILL state holds until the drain completes.
  - No valid_ifill_resp_o is produced for a dropped fill.
- Kill on the same cycle as the last beat: the fill is dropped and the FSM goes to IDLE.
- Kill in DONE is ignored; the line pulse still fires, and the controller masks it.
- l2_rsp_err_i on any beat sets the error flag. ifill_err_o = flag in DONE.
- ifill_line_o is registered and held stable from DONE until the next fill's first beat.
- Latency, with 1-cycle ready and back-to-back beats: request cycle t → l2_req_valid_o at t+1 → beats t+2..t+1+N_BEATS → valid_ifill_resp_o one cycle after the last beat.
- Reset mid-operation returns immediately to IDLE. Outstanding L2 beats after reset are the system's responsibility.

Optional Feature:
- Macro: SARGANTANA_ICACHE_IFILL_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in WAIT and clears on each beat.
  - When it reaches TIMEOUT_CYC, the FSM forces DONE with ifill_err_o = 1, or IDLE if the fill is dropped.
  - Extra output timeout_o pulses for one cycle.
  - Beats arriving later while in IDLE are ignored.
- Without the macro: no counter, no timeout_o port, and WAIT waits indefinitely.

Decomposition:
- Package sargantana_icache_pkg holds:
  - ifill_state_t enum (IDLE, REQ, WAIT, DONE), 2 bits.
  - Localparam helpers N_BEATS and BEAT_CNT_W.
  - Line offset width for address alignment.
- One sub-module is natural: sargantana_icache_line_buf, an N_BEATS×BEAT_W beat-indexed write register with a flat LINE_W read port. The FSM stays in the top.

Test Plan:
- Normal fill, N_BEATS=4:
  - Stimulus: request paddr 0x80001234; ready at once; beats 0xA..0xD back-to-back.
  - Response: l2_req_paddr_o = 0x80001200; four ifill_resp_valid_o pulses; valid_ifill_resp_o one cycle after the 4th beat; line = {D,C,B,A}; err = 0.
- Backpressure: l2_req_ready_i low for 5 cycles → l2_req_valid_o and the address stay stable for 6 cycles; no ack until the handshake.
- Kill after beat 1 → ifill_resp_valid_o only on beat 0; ack stays high through beat 3; no valid_ifill_resp_o; state IDLE the next cycle.
- Kill in REQ before ready → l2_req_valid_o drops the next cycle; no L2 handshake; IDLE.
- Error on beat 2 → valid_ifill_resp_o with ifill_err_o = 1. The next clean fill has ifill_err_o = 0.
- Timeout, macro on, TIMEOUT_CYC=16: one beat then silence → timeout_o pulses 16 cycles after beat 0, and valid_ifill_resp_o fires with ifill_err_o = 1.
